// File: rtl/gf_inv_pkg.sv
// Shared types and helpers for the Itoh-Tsujii inversion controller.
// Optional feature macro: GF_INV_ZERO_DETECT_EN (zero-operand short-cut in the top).
package gf_inv_pkg;

  // Default field degree
  localparam int unsigned M_DEFAULT = 8;

  // Controller state encoding
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSqr   = 3'd1,
    StMul   = 3'd2,
    StFinal = 3'd3,
    StDone  = 3'd4
  } gf_inv_state_e;

  // Which multiply the current chain step ends with: by saved beta or by a
  typedef enum logic {
    StepDbl = 1'b0,
    StepAdd = 1'b1
  } gf_inv_step_e;

  // Number of significant bits in (m - 1), i.e. the addition-chain length
  function automatic int unsigned chain_bits(input int unsigned m);
    int unsigned v;
    int unsigned n;
    v = m - 1;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/gf_inv_chain_seq.sv
// Addition-chain bookkeeping for Itoh-Tsujii: bit index into (M-1), current
// exponent length k, and the decode of what follows each multiply.
module gf_inv_chain_seq
  import gf_inv_pkg::*;
#(
  parameter int unsigned M  = M_DEFAULT,
  parameter int unsigned NB = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,     // new inversion accepted
  input  logic         adv,      // current multiply completed
  output gf_inv_step_e step,     // kind of multiply pending for this step
  output logic         last,     // the pending multiply is the final one of the chain
  output logic [NB-1:0] nxt_cnt  // squarings to perform before the next multiply
);

  localparam int unsigned CHAIN_BITS = chain_bits(M);
  localparam int unsigned IDX_INIT   = (CHAIN_BITS >= 2) ? CHAIN_BITS - 2 : 0;
  localparam logic [NB-1:0] EXP      = NB'(M - 1);

  gf_inv_step_e  step_q, step_d;
  logic [NB-1:0] idx_q, idx_d;
  logic [NB-1:0] k_q, k_d;
  logic          bit_set;

  assign bit_set = |(EXP & (NB'(1) << idx_q));
  assign step    = step_q;

  // Next chain position once the pending multiply completes
  always_comb begin
    step_d = step_q;
    idx_d  = idx_q;
    k_d    = k_q;
    last   = 1'b0;
    if (step_q == StepDbl) begin
      k_d = k_q << 1;
      if (bit_set) begin
        step_d = StepAdd;
      end else if (idx_q == '0) begin
        last = 1'b1;
      end else begin
        idx_d = idx_q - NB'(1);
      end
    end else begin
      k_d = k_q + NB'(1);
      if (idx_q == '0) begin
        last = 1'b1;
      end else begin
        idx_d  = idx_q - NB'(1);
        step_d = StepDbl;
      end
    end
    // An add step needs one squaring; a doubling needs k of them
    nxt_cnt = (step_d == StepAdd) ? NB'(1) : k_d;
  end

  // Chain position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= StepDbl;
      idx_q  <= '0;
      k_q    <= '0;
    end else if (init) begin
      step_q <= StepDbl;
      idx_q  <= NB'(IDX_INIT);
      k_q    <= NB'(1);
    end else if (adv) begin
      step_q <= step_d;
      idx_q  <= idx_d;
      k_q    <= k_d;
    end
  end

endmodule

// File: rtl/gf_inv_itoh_tsujii_ctrl.sv
// Itoh-Tsujii inversion sequencer for GF(2^M): a^-1 = (a^(2^(M-1)-1))^2.
// Drives an external combinational squarer and a req/ack multiplier.
// Optional macro GF_INV_ZERO_DETECT_EN: a zero operand skips the chain and flags inv_err.
module gf_inv_itoh_tsujii_ctrl
  import gf_inv_pkg::*;
#(
  parameter int unsigned M  = M_DEFAULT,
  parameter int unsigned NB = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] din,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] dout,
  output logic         inv_err,
  output logic [M-1:0] sq_din,
  input  logic [M-1:0] sq_dout,
  output logic         mul_req,
  output logic [M-1:0] mul_a,
  output logic [M-1:0] mul_b,
  input  logic         mul_ack,
  input  logic [M-1:0] mul_res
);

  localparam bit CHAIN_EMPTY = (chain_bits(M) < 2);

  gf_inv_state_e state_q, state_d;
  logic [M-1:0]  acc_q, beta_q, a_reg_q, dout_q;
  logic [NB-1:0] sq_cnt_q;
  logic          inv_err_q;

  logic          accept;
  logic          zero_hit;
  logic          chain_adv;
  logic          chain_last;
  logic [NB-1:0] chain_cnt;
  gf_inv_step_e  chain_step;

`ifdef GF_INV_ZERO_DETECT_EN
  assign zero_hit = (din == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign chain_adv = (state_q == StMul) && mul_ack;

  gf_inv_chain_seq #(
    .M  (M),
    .NB (NB)
  ) u_chain (
    .clk     (clk),
    .rst     (rst),
    .init    (accept),
    .adv     (chain_adv),
    .step    (chain_step),
    .last    (chain_last),
    .nxt_cnt (chain_cnt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    mul_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept = 1'b1;
          if (zero_hit)         state_d = StDone;
          else if (CHAIN_EMPTY) state_d = StFinal;
          else                  state_d = StSqr;
        end
      end
      StSqr: begin
        busy = 1'b1;
        if (sq_cnt_q == NB'(1)) state_d = StMul;
      end
      StMul: begin
        busy    = 1'b1;
        mul_req = 1'b1;
        if (mul_ack) state_d = chain_last ? StFinal : StSqr;
      end
      StFinal: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      beta_q    <= '0;
      a_reg_q   <= '0;
      dout_q    <= '0;
      sq_cnt_q  <= '0;
      inv_err_q <= 1'b0;
    end else if (accept) begin
      acc_q     <= din;
      beta_q    <= din;
      a_reg_q   <= din;
      sq_cnt_q  <= NB'(1);
      inv_err_q <= zero_hit;
      if (zero_hit) dout_q <= '0;
    end else begin
      unique case (state_q)
        StSqr: begin
          acc_q    <= sq_dout;
          sq_cnt_q <= sq_cnt_q - NB'(1);
        end
        StMul: begin
          if (mul_ack) begin
            acc_q    <= mul_res;
            beta_q   <= mul_res;
            sq_cnt_q <= chain_cnt;
          end
        end
        StFinal: begin
          // Result is captured here so it is visible alongside done
          acc_q  <= sq_dout;
          dout_q <= sq_dout;
        end
        default: ;
      endcase
    end
  end

  assign dout    = dout_q;
  assign inv_err = inv_err_q;
  assign sq_din  = acc_q;
  assign mul_a   = acc_q;
  assign mul_b   = (chain_step == StepDbl) ? beta_q : a_reg_q;

endmodule

// File: tb/tb_gf_inv_itoh_tsujii_ctrl.sv
// Self-checking bench for gf_inv_itoh_tsujii_ctrl (M=8, field poly x^8+x^4+x^3+x+1).
// Honours GF_INV_ZERO_DETECT_EN when defined.
module tb_gf_inv_itoh_tsujii_ctrl;

  logic       clk, rst, start;
  logic [7:0] din, dout, sq_din, sq_dout, mul_a, mul_b, mul_res;
  logic       busy, done, inv_err, mul_req, mul_ack;
  logic       m_ack, spur_ack;
  int         lat_cfg;
  int         mreq_rises;
  int         n_tests, n_fail;

  gf_inv_itoh_tsujii_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .inv_err (inv_err),
    .sq_din  (sq_din),
    .sq_dout (sq_dout),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_res (mul_res)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  assign sq_dout = gf_mul(sq_din, sq_din);
  assign mul_ack = m_ack | spur_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier model: acks lat_cfg cycles after it first sees mul_req
  initial begin
    logic [7:0] ca, cb;
    int rem;
    bit waiting;
    m_ack = 1'b0; mul_res = 8'h00; waiting = 0; rem = 0; ca = 0; cb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ack = 1'b0; waiting = 0;
      end else if (m_ack) begin
        m_ack = 1'b0;
      end else if (waiting) begin
        rem--;
        if (rem <= 0) begin
          mul_res = gf_mul(ca, cb); m_ack = 1'b1; waiting = 0;
        end
      end else if (mul_req) begin
        mreq_rises++; ca = mul_a; cb = mul_b; rem = lat_cfg; waiting = 1;
      end
    end
  end

  // One inversion; lat counts cycles from the start cycle through the done cycle inclusive
  task automatic run_inv(input logic [7:0] a, input int l, input bit flood, input bit spur,
                         output logic [7:0] res, output int lat, output int rises,
                         output int sqc, output logic err);
    bit got;
    @(negedge clk);
    din = a; start = 1'b1; lat_cfg = l; mreq_rises = 0;
    if (spur) spur_ack = 1'b1;
    lat = 1; sqc = 0; got = 0; res = 8'hxx; err = 1'bx;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (c == 1) spur_ack = 1'b0;
      if (!flood) start = 1'b0;
      else din = 8'h02;
      if (busy && !mul_req) sqc++;
      if (done) begin
        got = 1; res = dout; err = inv_err;
      end
    end
    start = 1'b0;
    spur_ack = 1'b0;
    rises = mreq_rises;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL run_timeout din=%02h: no done within 200 cycles", a);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, dout, inv_err, mul_req, sq_din, mul_a, mul_b} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, dout, inv_err, mul_req, sq_din, mul_a, mul_b});
    end
    rst = 1'b0;
  endtask

  task automatic check_run(input string nm, input logic [7:0] a, input int l,
                           input logic [7:0] exp_res, input int exp_lat);
    logic [7:0] r; int lat, rises, sqc; logic err;
    run_inv(a, l, 0, 0, r, lat, rises, sqc, err);
    n_tests++;
    if (r !== exp_res) begin
      n_fail++; $display("FAIL %s_dout got=%02h want=%02h", nm, r, exp_res);
    end
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, exp_lat);
    end
  endtask

  task automatic test_basic();
    logic [7:0] r; int lat, rises, sqc; logic err;
    run_inv(8'h01, 1, 0, 0, r, lat, rises, sqc, err);
    n_tests++;
    if (r !== 8'h01) begin n_fail++; $display("FAIL basic_dout got=%02h want=01", r); end
    n_tests++;
    if (lat !== 17) begin n_fail++; $display("FAIL basic_latency got=%0d want=17", lat); end
    n_tests++;
    if (rises !== 4) begin n_fail++; $display("FAIL basic_mul_reqs got=%0d want=4", rises); end
    n_tests++;
    if (sqc !== 7) begin n_fail++; $display("FAIL basic_squarings got=%0d want=7", sqc); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_inv_err got=%b want=0", err); end
  endtask

  task automatic test_directed();
    check_run("inv02", 8'h02, 1, 8'h8D, 17);
    check_run("inv53", 8'h53, 3, 8'hCA, 25);
    check_run("invCA", 8'hCA, 5, 8'h53, 33);
  endtask

  task automatic test_spurious_ack();
    logic [7:0] r; int lat, rises, sqc; logic err;
    run_inv(8'h53, 1, 0, 1, r, lat, rises, sqc, err);
    n_tests++;
    if (r !== 8'hCA) begin n_fail++; $display("FAIL spur_dout got=%02h want=CA", r); end
    n_tests++;
    if (lat !== 17) begin n_fail++; $display("FAIL spur_latency got=%0d want=17", lat); end
    n_tests++;
    if (rises !== 4) begin n_fail++; $display("FAIL spur_mul_reqs got=%0d want=4", rises); end
  endtask

  task automatic test_zero();
    logic [7:0] r; int lat, rises, sqc; logic err;
    run_inv(8'h00, 1, 0, 0, r, lat, rises, sqc, err);
    n_tests++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL zero_dout got=%02h want=00", r); end
`ifdef GF_INV_ZERO_DETECT_EN
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL zero_latency got=%0d want=2", lat); end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL zero_inv_err got=%b want=1", err); end
    n_tests++;
    if (rises !== 0) begin n_fail++; $display("FAIL zero_mul_reqs got=%0d want=0", rises); end
`else
    n_tests++;
    if (lat !== 17) begin n_fail++; $display("FAIL zero_latency got=%0d want=17", lat); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL zero_inv_err got=%b want=0", err); end
    n_tests++;
    if (rises !== 4) begin n_fail++; $display("FAIL zero_mul_reqs got=%0d want=4", rises); end
`endif
  endtask

  // start held high every cycle (including the done cycle), din scrambled mid-run
  task automatic test_back_to_back();
    logic [7:0] r; int lat, rises, sqc; logic err; int extra; bit busy_seen;
    run_inv(8'h53, 2, 1, 0, r, lat, rises, sqc, err);
    n_tests++;
    if (r !== 8'hCA) begin n_fail++; $display("FAIL flood_dout got=%02h want=CA", r); end
    n_tests++;
    if (lat !== 21) begin n_fail++; $display("FAIL flood_latency got=%0d want=21", lat); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL flood_inv_err got=%b want=0", err); end
    extra = 0; busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
      if (busy) busy_seen = 1;
    end
    n_tests++;
    if (extra !== 0 || busy_seen) begin
      n_fail++; $display("FAIL flood_extra_run dones=%0d busy=%b want 0/0", extra, busy_seen);
    end
  endtask

  task automatic test_rst_mid();
    bit seen;
    @(negedge clk);
    din = 8'h53; start = 1'b1; lat_cfg = 5;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (mul_req) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_no_mul_req within 40 cycles"); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({mul_req, busy, done, dout} !== 11'h0) begin
      n_fail++; $display("FAIL rstmid_outputs got=%h want=0", {mul_req, busy, done, dout});
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    check_run("after_rst", 8'h01, 1, 8'h01, 17);
  endtask

  task automatic test_random();
    logic [7:0] a, r; int l, lat, rises, sqc; logic err;
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(1, 255));
      l = $urandom_range(1, 5);
      run_inv(a, l, 0, 0, r, lat, rises, sqc, err);
      n_tests++;
      if (gf_mul(a, r) !== 8'h01) begin
        n_fail++; $display("FAIL rand_inverse a=%02h dout=%02h product=%02h want=01",
                           a, r, gf_mul(a, r));
      end
      n_tests++;
      if (lat !== 13 + 4 * l) begin
        n_fail++; $display("FAIL rand_latency a=%02h L=%0d got=%0d want=%0d",
                           a, l, lat, 13 + 4 * l);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mreq_rises = 0; lat_cfg = 1;
    rst = 1'b1; start = 1'b0; din = 8'h00; spur_ack = 1'b0;
    test_reset();
    test_basic();
    test_directed();
    test_spurious_ack();
    test_zero();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
